uart_transmisor: RTL

- Serial UART transmitter: the transmit-side counterpart of the existing receive path and its clock divider.
- Accepts one byte per valid/ready handshake and shifts it out as a single frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Bit timing is produced by an internal clocks-per-bit counter clocked from the system clock; no derived clock is used.
- Sits between the user logic and the board TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_transmisor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, idle level and default divider.
// Used by both the transmit path and the receive-side rework.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   UART_DATA_BITS       = 8;
    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   UART_CLK_DIV_DEFAULT = 434;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and pulses tick on the wrap cycle.
// restart forces the count back to zero so a new frame starts on a full bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !restart && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_transmisor.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (8E1); default build is 8N1.
module uart_transmisor
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV_DEFAULT,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e            state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic accept;
    logic tick;

    assign accept = tx_valid && tx_ready_q;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .en      (busy_q),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = even_parity(tx_data);
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                // Each boundary presents the current LSB and shifts the next bit down.
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d    = IDLE;
                    tx_d       = UART_IDLE_LEVEL;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_d       = UART_IDLE_LEVEL;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule
